tta_core_p: RTL and testbench

TTA_CORE_P -- requirements
Module: tta_core_p

---
 rtl/tta_pkg.sv | 51 +++++
 rtl/tta_decode.sv | 91 +++++++++
 rtl/tta_core_p.sv | 209 ++++++++++++++++++++
 tb/tb_tta_core_p.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tta_pkg.sv
// tta_pkg: state encoding, instruction field layout and address-map
// helpers shared by the transport-triggered core and its decoder.
package tta_pkg;

  // Width of the dest and src move addresses.
  localparam int unsigned AW = 7;

`ifdef TTA_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_e;
`endif

  // Flag and dest positions are counted down from the instruction MSB.
  localparam int unsigned F_VALID   = 1;
  localparam int unsigned F_COND    = 2;
  localparam int unsigned F_LIT     = 3;
  localparam int unsigned F_HL      = 4;
  localparam int unsigned F_DEST    = 5;
  localparam int unsigned F_SRC_LSB = 0;

  function automatic int unsigned op_base(
    input int unsigned nreg
  );
    return nreg;
  endfunction

  function automatic int unsigned res_base(
    input int unsigned nreg,
    input int unsigned nunits
  );
    return nreg + nunits;
  endfunction

  function automatic int unsigned map_end(
    input int unsigned nreg,
    input int unsigned nunits
  );
    return nreg + 2 * nunits;
  endfunction

endpackage

// File: rtl/tta_decode.sv
// tta_decode: splits an instruction word into its fields and classifies
// dest/src against the address map; *_sub_o is the index within a region.
// Ports: instr_i in; flags, literal, dest/src class and index out.
module tta_decode
  import tta_pkg::*;
#(
  parameter int unsigned DW     = 24,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NUNITS = 11
) (
  input  logic [DW-1:0]   instr_i,
  output logic            valid_o,
  output logic            cond_o,
  output logic            lit_o,
  output logic            hl_o,
  output logic [DW/2-1:0] lit_val_o,
  output logic [AW-1:0]   dst_sub_o,
  output logic            dst_reg_o,
  output logic            dst_op_o,
  output logic            dst_bad_o,
  output logic [AW-1:0]   src_sub_o,
  output logic            src_reg_o,
  output logic            src_op_o,
  output logic            src_res_o,
  output logic            src_bad_o
);

  localparam int unsigned OPB_I = op_base(NREG);
  localparam int unsigned RSB_I = res_base(NREG, NUNITS);
  localparam int unsigned END_I = map_end(NREG, NUNITS);
  localparam logic [AW:0] OPB = OPB_I[AW:0];
  localparam logic [AW:0] RSB = RSB_I[AW:0];
  localparam logic [AW:0] ENDB = END_I[AW:0];

  logic [AW-1:0] dst;
  logic [AW-1:0] src;
  logic [AW:0]   dst_w;
  logic [AW:0]   src_w;

  // The gap bit between literal and dest carries no meaning.
  logic unused_bits;
  assign unused_bits = ^instr_i;

  assign valid_o   = instr_i[DW-F_VALID];
  assign cond_o    = instr_i[DW-F_COND];
  assign lit_o     = instr_i[DW-F_LIT];
  assign hl_o      = instr_i[DW-F_HL];
  assign lit_val_o = instr_i[DW/2-1:0];

  assign dst   = instr_i[DW-F_DEST -: AW];
  assign src   = instr_i[F_SRC_LSB +: AW];
  assign dst_w = {1'b0, dst};
  assign src_w = {1'b0, src};

  always_comb begin
    dst_reg_o = 1'b0;
    dst_op_o  = 1'b0;
    dst_bad_o = 1'b0;
    dst_sub_o = dst;
    unique case (1'b1)
      (dst_w < OPB): dst_reg_o = 1'b1;
      (dst_w >= OPB && dst_w < RSB): begin
        dst_op_o  = 1'b1;
        dst_sub_o = dst - OPB[AW-1:0];
      end
      // result ports are read-only
      default: dst_bad_o = 1'b1;
    endcase
  end

  always_comb begin
    src_reg_o = 1'b0;
    src_op_o  = 1'b0;
    src_res_o = 1'b0;
    src_bad_o = 1'b0;
    src_sub_o = src;
    unique case (1'b1)
      (src_w < OPB): src_reg_o = 1'b1;
      (src_w >= OPB && src_w < RSB): begin
        src_op_o  = 1'b1;
        src_sub_o = src - OPB[AW-1:0];
      end
      (src_w >= RSB && src_w < ENDB): begin
        src_res_o = 1'b1;
        src_sub_o = src - RSB[AW-1:0];
      end
      default: src_bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/tta_core_p.sv
// tta_core_p: transport-triggered core; FETCH/EXEC/WB, one move each.
// Ports: clk, rst (sync, low), imem req/addr/valid/data, op_o, trig_o,
// res_i; err_o + HALT only when TTA_ILLEGAL_TRAP_EN is defined.
module tta_core_p
  import tta_pkg::*;
#(
  parameter int unsigned DW       = 24,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NUNITS   = 11,
  parameter int unsigned COND_IDX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_o,
  output logic [DW-1:0]        imem_addr_o,
  input  logic                 imem_valid_i,
  input  logic [DW-1:0]        imem_data_i,
  output logic [NUNITS*DW-1:0] op_o,
  output logic [NUNITS-1:0]    trig_o,
  input  logic [NUNITS*DW-1:0] res_i
`ifdef TTA_ILLEGAL_TRAP_EN
  ,
  output logic                 err_o
`endif
);

  localparam int unsigned HW = DW / 2;
  localparam int unsigned PC = NREG - 1;

  state_e            state_q, state_d;
  logic [DW-1:0]     instr_q, instr_d;
  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     regs_d [NREG];
  logic [DW-1:0]     ops_q  [NUNITS];
  logic [DW-1:0]     ops_d  [NUNITS];
  logic [DW-1:0]     res_q  [NUNITS];
  logic [DW-1:0]     res_d  [NUNITS];
  logic [NUNITS-1:0] trig_q, trig_d;
`ifdef TTA_ILLEGAL_TRAP_EN
  logic              err_q, err_d;
`endif

  logic          d_valid, d_cond, d_lit, d_hl;
  logic [HW-1:0] d_lit_val;
  logic [AW-1:0] d_dst_sub, d_src_sub;
  logic          d_dst_reg, d_dst_op, d_dst_bad;
  logic          d_src_reg, d_src_op, d_src_res, d_src_bad;

  tta_decode #(
    .DW    (DW),
    .NREG  (NREG),
    .NUNITS(NUNITS)
  ) u_dec (
    .instr_i  (instr_q),
    .valid_o  (d_valid),
    .cond_o   (d_cond),
    .lit_o    (d_lit),
    .hl_o     (d_hl),
    .lit_val_o(d_lit_val),
    .dst_sub_o(d_dst_sub),
    .dst_reg_o(d_dst_reg),
    .dst_op_o (d_dst_op),
    .dst_bad_o(d_dst_bad),
    .src_sub_o(d_src_sub),
    .src_reg_o(d_src_reg),
    .src_op_o (d_src_op),
    .src_res_o(d_src_res),
    .src_bad_o(d_src_bad)
  );

  logic [DW-1:0] src_val;
  logic [DW-1:0] dst_old;
  logic [DW-1:0] wr_val;
  logic          cond_ok;
  logic          illegal;
  logic          mv_ok;

  // R0 is never written, so the loops start at 1 and R0 reads as 0.
  always_comb begin
    src_val = '0;
    for (int k = 1; k < NREG; k++) begin
      if (d_src_reg && d_src_sub == AW'(k)) src_val = regs_q[k];
    end
    for (int k = 0; k < NUNITS; k++) begin
      if (d_src_op && d_src_sub == AW'(k)) src_val = ops_q[k];
      if (d_src_res && d_src_sub == AW'(k)) src_val = res_q[k];
    end
  end

  // Current dest contents, kept for literal half-writes.
  always_comb begin
    dst_old = '0;
    for (int k = 1; k < NREG; k++) begin
      if (d_dst_reg && d_dst_sub == AW'(k)) dst_old = regs_q[k];
    end
    for (int k = 0; k < NUNITS; k++) begin
      if (d_dst_op && d_dst_sub == AW'(k)) dst_old = ops_q[k];
    end
  end

  always_comb begin
    wr_val = src_val;
    unique case (1'b1)
      (d_lit && d_hl):  wr_val = {d_lit_val, dst_old[HW-1:0]};
      (d_lit && !d_hl): wr_val = {dst_old[DW-1:HW], d_lit_val};
      default:          wr_val = src_val;
    endcase
  end

  assign cond_ok = !d_cond || res_q[COND_IDX][0];
  assign illegal = !d_valid || d_dst_bad || (!d_lit && d_src_bad);
  assign mv_ok   = !illegal && cond_ok;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    regs_d     = regs_q;
    ops_d      = ops_q;
    res_d      = res_q;
    trig_d     = '0;
`ifdef TTA_ILLEGAL_TRAP_EN
    err_d      = err_q;
`endif
    imem_req_o = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_valid_i) begin
          instr_d    = imem_data_i;
          regs_d[PC] = regs_q[PC] + DW'(1);
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
`ifdef TTA_ILLEGAL_TRAP_EN
        if (illegal) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
`endif
        // A PC write here replaces the increment done in FETCH.
        if (mv_ok) begin
          for (int k = 1; k < NREG; k++) begin
            if (d_dst_reg && d_dst_sub == AW'(k)) regs_d[k] = wr_val;
          end
          for (int k = 0; k < NUNITS; k++) begin
            if (d_dst_op && d_dst_sub == AW'(k)) begin
              ops_d[k]  = wr_val;
              trig_d[k] = 1'b1;
            end
          end
        end
      end
      S_WB: begin
        for (int k = 0; k < NUNITS; k++) begin
          res_d[k] = res_i[k*DW +: DW];
        end
        state_d = S_FETCH;
      end
`ifdef TTA_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      trig_q  <= '0;
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      for (int k = 0; k < NUNITS; k++) begin
        ops_q[k] <= '0;
        res_q[k] <= '0;
      end
`ifdef TTA_ILLEGAL_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      trig_q  <= trig_d;
      for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
      for (int k = 0; k < NUNITS; k++) begin
        ops_q[k] <= ops_d[k];
        res_q[k] <= res_d[k];
      end
`ifdef TTA_ILLEGAL_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  assign imem_addr_o = regs_q[PC];
  assign trig_o      = trig_q;
`ifdef TTA_ILLEGAL_TRAP_EN
  assign err_o       = err_q;
`endif

  always_comb begin
    op_o = '0;
    for (int k = 0; k < NUNITS; k++) begin
      op_o[k*DW +: DW] = ops_q[k];
    end
  end

endmodule

// File: tb/tb_tta_core_p.sv
// tb_tta_core_p: directed table, corner sequences and random moves
// checked against an instruction-level model of the core.
`timescale 1ns/1ps
module tb_tta_core_p;

  localparam int DW   = 24;
  localparam int NREG = 32;
  localparam int NU   = 11;
  localparam int OW   = NU * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_o;
  logic [DW-1:0] imem_addr_o;
  logic          imem_valid_i;
  logic [DW-1:0] imem_data_i;
  logic [OW-1:0] op_o;
  logic [NU-1:0] trig_o;
  logic [OW-1:0] res_i;
`ifdef TTA_ILLEGAL_TRAP_EN
  logic          err_o;
`endif

  tta_core_p #(
    .DW(DW), .NREG(NREG), .NUNITS(NU), .COND_IDX(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_valid_i(imem_valid_i),
    .imem_data_i (imem_data_i),
    .op_o        (op_o),
    .trig_o      (trig_o),
    .res_i       (res_i)
`ifdef TTA_ILLEGAL_TRAP_EN
    ,
    .err_o       (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Architectural model: m_reg[31] is the PC.
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] m_op  [NU];
  logic [DW-1:0] m_res [NU];

  task automatic chk(input string name,
                     input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_reg[k] = '0;
    for (int k = 0; k < NU; k++) begin
      m_op[k]  = '0;
      m_res[k] = '0;
    end
  endtask

  function automatic logic [DW-1:0] mread(input int a);
    if (a == 0) return '0;
    if (a < NREG) return m_reg[a];
    if (a < NREG + NU) return m_op[a-NREG];
    return m_res[a-NREG-NU];
  endfunction

  function automatic logic [OW-1:0] pack_ops();
    logic [OW-1:0] v;
    for (int k = 0; k < NU; k++) v[k*DW +: DW] = m_op[k];
    return v;
  endfunction

  task automatic model_exec(input logic [DW-1:0] ins,
                            output logic [NU-1:0] trg);
    int d;
    int s;
    logic [DW-1:0] v;
    logic [DW-1:0] old;
    trg = '0;
    d = int'(ins[19:13]);
    s = int'(ins[6:0]);
    if (!ins[23]) return;
    if (ins[22] && !m_res[2][0]) return;
    if (d >= NREG + NU) return;
    if (!ins[21] && s >= NREG + 2 * NU) return;
    old = mread(d);
    if (ins[21])
      v = ins[20] ? {ins[11:0], old[11:0]} : {old[23:12], ins[11:0]};
    else
      v = mread(s);
    if (d >= NREG) begin
      m_op[d-NREG] = v;
      trg[d-NREG]  = 1'b1;
    end else if (d != 0) begin
      m_reg[d] = v;
    end
  endtask

  function automatic logic [DW-1:0] enc_lit(input logic hl,
                                            input logic [6:0] d,
                                            input logic [11:0] v);
    return {1'b1, 1'b0, 1'b1, hl, d, 1'b0, v};
  endfunction

  function automatic logic [DW-1:0] enc_mv(input logic c,
                                           input logic [6:0] d,
                                           input logic [6:0] s);
    return {1'b1, c, 2'b00, d, 6'b0, s};
  endfunction

  // Entered in FETCH, #1 after an edge; returns in the next FETCH.
  task automatic run_instr(input logic [DW-1:0] ins,
                           input int stall,
                           input logic [OW-1:0] rv,
                           output logic [DW-1:0] got_addr,
                           output logic [NU-1:0] got_trg,
                           output logic [OW-1:0] got_op);
    logic [NU-1:0] etrg;
    for (int s = 0; s < stall; s++) begin
      imem_valid_i = 1'b0;
      imem_data_i  = DW'($urandom);
      @(posedge clk);
      #1;
      chk("stall_addr", imem_addr_o, m_reg[NREG-1]);
      chk("stall_req", imem_req_o, 1'b1);
      chk("stall_trig", trig_o, '0);
    end
    got_addr = imem_addr_o;
    chk("fetch_req", imem_req_o, 1'b1);
    chk("fetch_addr", imem_addr_o, m_reg[NREG-1]);
    imem_valid_i = 1'b1;
    imem_data_i  = ins;
    @(posedge clk);
    #1;
    m_reg[NREG-1] = m_reg[NREG-1] + DW'(1);
    model_exec(ins, etrg);
    // Traffic outside FETCH must be ignored.
    imem_valid_i = 1'($urandom);
    imem_data_i  = DW'($urandom);
    @(posedge clk);
    #1;
    got_trg = trig_o;
    got_op  = op_o;
    chk("wb_trig", trig_o, etrg);
    chk("wb_ops", op_o, pack_ops());
    res_i = rv;
    @(posedge clk);
    #1;
    for (int k = 0; k < NU; k++) m_res[k] = rv[k*DW +: DW];
    chk("post_trig", trig_o, '0);
    imem_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] ins;
    logic [DW-1:0] r2;
    logic [NU-1:0] trg;
    int            k;
    logic [DW-1:0] opv;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [DW-1:0] ga;
    logic [NU-1:0] gt;
    logic [OW-1:0] go;
    logic [OW-1:0] rv;
    logic [DW-1:0] nop_ins;

    nop_ins = enc_mv(1'b0, 7'd32, 7'd1);
`ifdef TTA_ILLEGAL_TRAP_EN
    nop_ins[22] = 1'b1;
`else
    nop_ins[23] = 1'b0;
`endif
    tbl[0]  = '{enc_lit(1'b0, 7'd1, 12'h123), 24'h0, 11'h000, 0, 24'h000000};
    tbl[1]  = '{enc_mv(1'b0, 7'd32, 7'd1), 24'h0, 11'h001, 0, 24'h000123};
    tbl[2]  = '{enc_lit(1'b1, 7'd1, 12'hABC), 24'h0, 11'h000, 0, 24'h000123};
    tbl[3]  = '{enc_mv(1'b0, 7'd32, 7'd1), 24'h0, 11'h001, 0, 24'hABC123};
    tbl[4]  = '{enc_lit(1'b0, 7'd33, 12'h055), 24'h0, 11'h002, 1, 24'h000055};
    tbl[5]  = '{enc_lit(1'b1, 7'd33, 12'hFFF), 24'h0, 11'h002, 1, 24'hFFF055};
    tbl[6]  = '{enc_mv(1'b0, 7'd32, 7'd0), 24'h0, 11'h001, 0, 24'h000000};
    tbl[7]  = '{nop_ins, 24'h0, 11'h000, 0, 24'h000000};
    tbl[8]  = '{enc_mv(1'b0, 7'd0, 7'd1), 24'h0, 11'h000, 0, 24'h000000};
    tbl[9]  = '{enc_mv(1'b0, 7'd34, 7'd0), 24'h0, 11'h004, 2, 24'h000000};
    tbl[10] = '{enc_mv(1'b1, 7'd35, 7'd1), 24'h1, 11'h000, 3, 24'h000000};
    tbl[11] = '{enc_mv(1'b1, 7'd35, 7'd1), 24'hABCD, 11'h008, 3, 24'hABC123};
    tbl[12] = '{enc_mv(1'b0, 7'd36, 7'd45), 24'h0, 11'h010, 4, 24'h00ABCD};
    tbl[13] = '{enc_mv(1'b1, 7'd37, 7'd1), 24'h0, 11'h000, 5, 24'h000000};
    tbl[14] = '{enc_mv(1'b0, 7'd38, 7'd31), 24'h0, 11'h040, 6, 24'h00000F};

    rst          = 1'b0;
    imem_valid_i = 1'b0;
    imem_data_i  = '0;
    res_i        = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req_o, 1'b1);
    chk("rst_addr", imem_addr_o, '0);
    chk("rst_trig", trig_o, '0);
    chk("rst_ops", op_o, '0);
`ifdef TTA_ILLEGAL_TRAP_EN
    chk("rst_err", err_o, 1'b0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      rv = '0;
      rv[2*DW +: DW] = tbl[i].r2;
      run_instr(tbl[i].ins, 0, rv, ga, gt, go);
      chk("tbl_addr", ga, DW'(i));
      chk("tbl_trig", gt, tbl[i].trg);
      chk("tbl_op", go[tbl[i].k*DW +: DW], tbl[i].opv);
    end

    // Long fetch stall, then one instruction.
    run_instr(enc_lit(1'b0, 7'd2, 12'h777), 5, '0, ga, gt, go);
    chk("stall_next_addr", imem_addr_o, 24'd16);

    // Jump by two literal half-writes to the PC.
    run_instr(enc_lit(1'b1, 7'd31, 12'h000), 0, '0, ga, gt, go);
    run_instr(enc_lit(1'b0, 7'd31, 12'h010), 0, '0, ga, gt, go);
    chk("pc_jump", imem_addr_o, 24'h10);

    for (int n = 0; n < 300; n++) begin
      logic [DW-1:0] ins;
      logic [OW-1:0] rr;
      ins = DW'($urandom);
      if ($urandom_range(0, 7) != 0) ins[19:13] = 7'($urandom_range(0, 47));
      if (!ins[21] && $urandom_range(0, 3) != 0)
        ins[6:0] = 7'($urandom_range(0, 53));
      if ($urandom_range(0, 7) != 0) ins[23] = 1'b1;
`ifdef TTA_ILLEGAL_TRAP_EN
      ins[23] = 1'b1;
      ins[19:13] = 7'($urandom_range(0, 42));
      if (!ins[21]) ins[6:0] = 7'($urandom_range(0, 53));
`endif
      for (int k = 0; k < NU; k++) rr[k*DW +: DW] = DW'($urandom);
      run_instr(ins, $urandom_range(0, 2), rr, ga, gt, go);
    end

`ifdef TTA_ILLEGAL_TRAP_EN
    imem_valid_i = 1'b1;
    imem_data_i  = enc_mv(1'b0, 7'd100, 7'd1);
    @(posedge clk);
    #1;
    imem_data_i = enc_lit(1'b0, 7'd32, 12'h5A5);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("halt_err", err_o, 1'b1);
      chk("halt_req", imem_req_o, 1'b0);
      chk("halt_trig", trig_o, '0);
      chk("halt_ops", op_o, pack_ops());
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("trap_rst_err", err_o, 1'b0);
    chk("trap_rst_req", imem_req_o, 1'b1);
    chk("trap_rst_addr", imem_addr_o, '0);
    imem_valid_i = 1'b0;
`endif

    // Reset while stalled in FETCH, then restart from address 0.
    imem_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    chk("midrst_addr", imem_addr_o, '0);
    chk("midrst_req", imem_req_o, 1'b1);
    chk("midrst_ops", op_o, '0);
    chk("midrst_trig", trig_o, '0);
    run_instr(enc_mv(1'b0, 7'd32, 7'd31), 0, '0, ga, gt, go);
    chk("midrst_pcread", go[DW-1:0], 24'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
